comp2_serial_unit: RTL and testbench

Parametrised, sequential two's-complement unit. It accepts a WIDTH-bit word over a valid/ready handshake and produces either its negation or its absolute value. The result is computed LSB-first, BPC bits per cycle, using the copy-until-first-one-then-invert rule. It replaces fixed-width combinational complementers in datapaths where area matters more than latency, and adds an abs mode and an overflow flag.

---
 rtl/comp2_pkg.sv | 13 +
 rtl/comp2_slice.sv | 23 ++
 rtl/comp2_serial_unit.sv | 96 +++++++++
 tb/tb_comp2_serial_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/comp2_pkg.sv
// Shared types and constants for the bit-serial two's-complement unit.
package comp2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_NEG = 1'b0;
    localparam logic MODE_ABS = 1'b1;

endpackage

// File: rtl/comp2_slice.sv
// Copy-until-first-one-then-invert ripple over BPC bits, LSB first.
module comp2_slice #(
    parameter int BPC = 1
) (
    input  logic [BPC-1:0] bits,
    input  logic           seen_in,
    input  logic           inv,
    output logic [BPC-1:0] res,
    output logic           seen_out
);

    always_comb begin
        logic seen;
        seen = seen_in;
        res  = '0;
        for (int i = 0; i < BPC; i++) begin
            res[i] = bits[i] ^ (seen & inv);
            seen   = seen | bits[i];
        end
        seen_out = seen;
    end

endmodule

// File: rtl/comp2_serial_unit.sv
// Sequential negate / absolute-value unit: WIDTH-bit word in, result
// produced BPC bits per cycle LSB-first, overflow flagged for the most-negative input.
module comp2_serial_unit
    import comp2_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf
);

    localparam int NBEATS = WIDTH / BPC;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("comp2_serial_unit: WIDTH must be >= 2 and a multiple of BPC");
        end
    endgenerate

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     sh_q, res_q;
    logic                 inv_q, seen_q, ovf_q;
    logic [CW-1:0]        beat_q;
    logic [BPC-1:0]       slice_res;
    logic                 slice_seen;
    logic                 accept, last_beat, inv_d;
    logic [WIDTH+BPC-1:0] res_cat;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = res_q;
    assign out_ovf   = ovf_q;

    assign accept    = in_valid & in_ready;
    assign last_beat = (beat_q == CW'(NBEATS - 1));
    assign inv_d     = (in_mode == MODE_NEG) | in_data[WIDTH-1];
    // New result bits enter from the MSB side; older bits move toward the LSB.
    assign res_cat   = {slice_res, res_q};

    comp2_slice #(.BPC(BPC)) u_slice (
        .bits     (sh_q[BPC-1:0]),
        .seen_in  (seen_q),
        .inv      (inv_q),
        .res      (slice_res),
        .seen_out (slice_seen)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_beat) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= '0;
            res_q  <= '0;
            inv_q  <= 1'b0;
            seen_q <= 1'b0;
            ovf_q  <= 1'b0;
            beat_q <= '0;
        end else if (accept) begin
            sh_q   <= in_data;
            inv_q  <= inv_d;
            seen_q <= 1'b0;
            ovf_q  <= inv_d & (in_data == MOST_NEG);
            beat_q <= '0;
        end else if (state_q == RUN) begin
            sh_q   <= sh_q >> BPC;
            res_q  <= res_cat[WIDTH+BPC-1:BPC];
            seen_q <= slice_seen;
            beat_q <= beat_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_comp2_serial_unit.sv
// Scoreboard bench: a BPC=1 instance for directed cases, a BPC=4 instance for the exhaustive sweep.
module tb_comp2_serial_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_ovf;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_ovf;
    logic [7:0] b_in_data, b_out_data;

    comp2_serial_unit #(.WIDTH(8), .BPC(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf)
    );

    comp2_serial_unit #(.WIDTH(8), .BPC(4)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    int unsigned lat_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: {ovf, result} from arithmetic negation, not from the serial rule.
    function automatic logic [8:0] model(input logic [7:0] d, input logic m);
        logic       inv;
        logic [7:0] r;
        inv = (m == 1'b0) || d[7];
        r   = inv ? (8'h00 - d) : d;
        return {inv && (d == 8'h80), r};
    endfunction

    task automatic run_a(input logic [7:0] d, input logic m, input string name);
        logic [8:0] exp;
        int         lat;
        @(negedge clk);
        total++;
        if (a_in_ready !== 1'b1) begin
            bad++; $display("FAIL %s ready_before_accept got=%b want=1", name, a_in_ready);
        end
        a_in_data = d; a_in_mode = m; a_in_valid = 1'b1; a_out_ready = 1'b1;
        qa.push_back(model(d, m));
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_in_data = ~d;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        total++;
        if (lat != 8) begin
            bad++; $display("FAIL %s latency got=%0d want=8", name, lat);
        end
        exp = qa.pop_front();
        total++;
        if ({a_out_ovf, a_out_data} !== exp) begin
            bad++; $display("FAIL %s result got ovf=%b data=%h want ovf=%b data=%h",
                            name, a_out_ovf, a_out_data, exp[8], exp[7:0]);
        end
        @(posedge clk); #1;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL %s back_to_idle got valid=%b ready=%b want 0/1",
                            name, a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_mode = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_mode = 0; b_out_ready = 0;
        #12;
        total++;
        if ({a_in_ready, a_out_valid, a_out_ovf, a_out_data} !== 11'b100_0000_0000) begin
            bad++; $display("FAIL reset_a got ready=%b valid=%b ovf=%b data=%h want 1/0/0/00",
                            a_in_ready, a_out_valid, a_out_ovf, a_out_data);
        end
        total++;
        if ({b_in_ready, b_out_valid, b_out_ovf, b_out_data} !== 11'b100_0000_0000) begin
            bad++; $display("FAIL reset_b got ready=%b valid=%b ovf=%b data=%h want 1/0/0/00",
                            b_in_ready, b_out_valid, b_out_ovf, b_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        run_a(8'h05, 1'b0, "neg_05");
        run_a(8'hF6, 1'b1, "abs_F6");
        run_a(8'h0A, 1'b1, "abs_0A");
        run_a(8'h00, 1'b0, "neg_00");
        run_a(8'h80, 1'b0, "neg_80");
        run_a(8'h80, 1'b1, "abs_80");
        run_a(8'h7F, 1'b1, "abs_7F");
        run_a(8'h7F, 1'b0, "neg_7F");
    endtask

    task automatic test_backpressure();
        logic [8:0] exp;
        int         lat;
        @(negedge clk);
        a_in_data = 8'h33; a_in_mode = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b0;
        qa.push_back(model(8'h33, 1'b0));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (a_out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        exp = qa.pop_front();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_in_data = 8'($urandom); a_in_mode = 1'($urandom); a_in_valid = 1'b1;
            @(posedge clk); #1;
            total++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || {a_out_ovf, a_out_data} !== exp) begin
                bad++; $display("FAIL bp_hold cycle=%0d got valid=%b ready=%b ovf=%b data=%h want 1/0/%b/%h",
                                k, a_out_valid, a_in_ready, a_out_ovf, a_out_data, exp[8], exp[7:0]);
            end
        end
        @(negedge clk);
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", a_out_valid, a_in_ready);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
                bad++; $display("FAIL bp_single_transfer got valid=%b ready=%b want 0/1",
                                a_out_valid, a_in_ready);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        a_in_data = 8'h55; a_in_mode = 1'b0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_out_data !== 8'h00) begin
            bad++; $display("FAIL async_reset got valid=%b ready=%b data=%h want 0/1/00",
                            a_out_valid, a_in_ready, a_out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_a(8'h01, 1'b0, "post_reset_01");
    endtask

    task automatic test_sweep_bpc4();
        int          got;
        int unsigned limit;
        got   = 0;
        limit = cyc + 20000;
        @(negedge clk);
        fork
            begin : driver
                for (int i = 0; i < 512; i++) begin
                    logic [7:0] d;
                    logic       m;
                    d = i[7:0];
                    m = i[8];
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    b_in_data = d; b_in_mode = m; b_in_valid = 1'b1;
                    while (b_in_ready !== 1'b1 && cyc < limit) @(negedge clk);
                    if (cyc >= limit) break;
                    @(negedge clk);
                    qb.push_back(model(d, m));
                    lat_q.push_back(cyc);
                    b_in_valid = 1'b0;
                    b_in_data  = 8'($urandom);
                end
                b_in_valid = 1'b0;
            end
            begin : monitor
                logic        prev;
                logic        r;
                logic [8:0]  exp;
                int unsigned acc;
                prev = 1'b0;
                while (got < 512 && cyc < limit) begin
                    @(negedge clk);
                    if (b_out_valid === 1'b1 && !prev) begin
                        total++;
                        if (lat_q.size() == 0) begin
                            bad++; $display("FAIL sweep_unexpected_output got data=%h want no output", b_out_data);
                        end else begin
                            acc = lat_q.pop_front();
                            if (cyc - acc != 2) begin
                                bad++; $display("FAIL sweep_latency got=%0d want=2", cyc - acc);
                            end
                        end
                    end
                    prev = b_out_valid;
                    r = ($urandom_range(0, 3) != 0);
                    b_out_ready = r;
                    if (b_out_valid === 1'b1 && r) begin
                        total++;
                        if (qb.size() == 0) begin
                            bad++; $display("FAIL sweep_empty_scoreboard got data=%h", b_out_data);
                        end else begin
                            exp = qb.pop_front();
                            if ({b_out_ovf, b_out_data} !== exp) begin
                                bad++; $display("FAIL sweep_result idx=%0d got ovf=%b data=%h want ovf=%b data=%h",
                                                got, b_out_ovf, b_out_data, exp[8], exp[7:0]);
                            end
                        end
                        got++;
                    end
                end
                b_out_ready = 1'b0;
            end
        join
        total++;
        if (got != 512) begin
            bad++; $display("FAIL sweep_timeout got=%0d results want=512", got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_sweep_bpc4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
